pipeline_merge_packet_scheduler: RTL and testbench
==================================================

// Module: pipeline_merge_packet_scheduler
// PURPOSE
// Shares one output ready/valid pipeline among INPUT_COUNT packet sources.
// Whole packets are granted round-robin; a grant is held from the first beat
// until the beat flagged last is accepted, so packets never interleave.
// Sits ahead of a shared downstream pipeline, e.g. a common memory write port.
// PARAMETERS
// WORD_WIDTH    8  data bits per beat
// INPUT_COUNT   4  number of requesters, >= 2
// MAX_BEATS     16 beat limit per grant; 0 = unlimited
// PORTS
// clock         in   1                       rising-edge clock
// clear         in   1                       async active-high reset
// input_valid   in   INPUT_COUNT             per-input beat valid
// input_ready   out  INPUT_COUNT             per-input beat ready
// input_last    in   INPUT_COUNT             per-input beat is last of packet
// input_data    in   WORD_WIDTH*INPUT_COUNT  input j at [WORD_WIDTH*j +: WORD_WIDTH]
// output_valid  out  1                       merged beat valid
// output_ready  in   1                       merged beat ready
// output_last   out  1                       merged beat last
// output_data   out  WORD_WIDTH              merged beat data
// grant         out  INPUT_COUNT             one-hot current owner; zero when idle
// BEHAVIOUR
// - Reset is asynchronous on clear high. While clear is high and after release:
//   output_valid=0, output_last=0, output_data=0, grant=0, input_ready=0,
//   state=IDLE, round-robin pointer=0 (input 0 has highest priority first).
// - Handshake: a transfer occurs when valid && ready are high on a rising edge.
//   Every interface holds valid, data and last stable until it transfers.
// - No combinational path from any input_valid to any input_ready, or from
//   output_ready to input_ready. input_ready[j] = (state==BUSY) && grant[j]
//   && output_buffer_not_full. All three terms are registers.
// - FSM, IDLE: if any input_valid is high, pick the first valid input at or
//   after the pointer (wrapping), register it as a one-hot grant, go to BUSY.
//   The decision costs 1 cycle, so the first beat has input_ready high one
//   cycle after input_valid rises.
// - FSM, BUSY: accept beats from the granted input only. Leave for IDLE when
//   (a) a beat with input_last=1 is accepted, or (b) MAX_BEATS!=0 and the
//   MAX_BEATS-th beat is accepted. On exit: grant<=0, and the pointer moves to
//   owner+1 mod INPUT_COUNT.
// - Case (b) forces output_last=1 on that beat. The remainder of the packet
//   re-arbitrates as a new packet.
// - The beat counter is ceil(log2(MAX_BEATS+1)) bits. It resets to 0 on each
//   grant and saturates, never wraps.
// - Output stage is a 2-entry skid buffer holding {last,data}. It registers
//   output_valid and output_data, giving 1 cycle latency from input to output
//   accept. Full throughput is 1 beat/cycle while output_ready stays high.
// - output_buffer_not_full is registered. It deasserts one cycle after a stall
//   fills the first entry; the second entry absorbs the beat in flight.
// - Simultaneous events:
//   * last accepted while another input is valid: IDLE for 1 cycle, then grant
//     the next input in round-robin order. Arbitration bubble is 1 cycle.
//   * Owner drops input_valid mid-packet: grant is held and nothing is sent.
//   * Only the owner requests again: it is re-granted after the IDLE cycle.
// - clear asserted mid-packet discards buffered beats and the partial packet.
//   Sources must restart their packets after reset.
// STRUCTURE
// - Shared package: state encoding (IDLE=1'b0, BUSY=1'b1), the clog2 helper,
//   and the beat-counter width function.
// - One sub-module: arbiter_round_robin_mask (combinational). Inputs are the
//   requests and a one-hot pointer; output is the one-hot grant of the first
//   request at or after the pointer. It is implemented as a double-width
//   priority find, with the FSM registering its output.
// - The output skid buffer, data mux (one-hot AND-OR), FSM and counter are
//   inline in this module.
// TESTING
// 1 Reset: clear=1 with random inputs, then release -> all outputs 0, and
//   grant=0001 one cycle after input_valid=0001.
// 2 Round-robin: all 4 inputs send 1-beat packets (last=1) continuously,
//   output_ready=1 -> grant order 0,1,2,3,0...; data tags 0xA0,0xB0,0xC0,0xD0
//   repeating; one idle cycle between packets.
// 3 No interleave: input 0 sends 5 beats 0x01..0x05 (last on 0x05) while
//   input 1 is valid -> output 01..05 contiguous, then input 1's beats.
// 4 Backpressure: output_ready toggles 1,0,0,1 during an 8-beat packet ->
//   no beat lost or duplicated; output_data holds while valid&&!ready.
// 5 MAX_BEATS=16, 20-beat packet on input 2 with input 3 valid -> beat 16 has
//   output_last=1; input 3's packet goes next; input 2's 4 remaining beats
//   follow, last=1 on beat 20.
// 6 Reset mid-packet: clear pulse after beat 3 of 6 -> output_valid=0
//   immediately (async); a fresh packet after release merges normally.

Source files
------------

// File: rtl/pipeline_merge_packet_scheduler_pkg.sv
// Shared definitions for the packet merge scheduler: FSM state encoding and
// the width helpers for the per-grant beat counter.
package pipeline_merge_packet_scheduler_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A zero-width counter is not legal, so the unlimited case still gets one bit.
    function automatic int beat_cnt_width(input int max_beats);
        int w;
        w = clog2(max_beats + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pipeline_merge_packet_scheduler_arbiter_round_robin_mask.sv
// Combinational round-robin pick: one-hot grant of the first request at or
// after the one-hot pointer, found with a double-width lowest-set-bit search.
module arbiter_round_robin_mask #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] gnt
);

    localparam int DN = 2 * N;

    logic [N-1:0]  below_ptr;
    logic [DN-1:0] dbl_req;
    logic [DN-1:0] dbl_gnt;

    always_comb begin
        below_ptr = ptr - N'(1);
        // Lower half sees only requests at/after the pointer; upper half wraps.
        dbl_req   = {req, req & ~below_ptr};
        dbl_gnt   = dbl_req & ~(dbl_req - DN'(1));
        gnt       = dbl_gnt[N-1:0] | dbl_gnt[DN-1:N];
    end

endmodule

// File: rtl/pipeline_merge_packet_scheduler.sv
// Merges INPUT_COUNT ready/valid packet sources onto one output pipeline,
// granting whole packets (or MAX_BEATS chunks) round-robin through a skid buffer.
module pipeline_merge_packet_scheduler
    import pipeline_merge_packet_scheduler_pkg::*;
#(
    parameter int WORD_WIDTH  = 8,
    parameter int INPUT_COUNT = 4,
    parameter int MAX_BEATS   = 16
) (
    input  logic                              clock,
    input  logic                              clear,
    input  logic [INPUT_COUNT-1:0]            input_valid,
    output logic [INPUT_COUNT-1:0]            input_ready,
    input  logic [INPUT_COUNT-1:0]            input_last,
    input  logic [WORD_WIDTH*INPUT_COUNT-1:0] input_data,
    output logic                              output_valid,
    input  logic                              output_ready,
    output logic                              output_last,
    output logic [WORD_WIDTH-1:0]             output_data,
    output logic [INPUT_COUNT-1:0]            grant
);

    // state | meaning
    // IDLE  | no owner; arbitrate among valid inputs this cycle
    // BUSY  | grant held; accept beats from owner until last or beat limit

    localparam int N  = INPUT_COUNT;
    localparam int CW = beat_cnt_width(MAX_BEATS);
    localparam logic [CW-1:0] LIMIT    = CW'(MAX_BEATS);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(MAX_BEATS - 1);
    localparam logic [CW-1:0] CNT_MAX  = (MAX_BEATS != 0) ? LIMIT : {CW{1'b1}};

    state_t              state, state_next;
    logic [N-1:0]        grant_next, ptr, ptr_next, arb_gnt;
    logic [CW-1:0]       cnt, cnt_next;
    logic                buf_nf;
    logic                accept, pop, cnt_hit, beat_last;
    logic [WORD_WIDTH-1:0] sel_data;
    logic                sel_last;
    logic                skid_valid;
    logic [WORD_WIDTH:0] skid_beat;
    logic [1:0]          occ_next;

    arbiter_round_robin_mask #(.N(N)) u_arb (
        .req (input_valid),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int j = 0; j < N; j++) begin
            sel_data = sel_data | (input_data[WORD_WIDTH*j +: WORD_WIDTH] & {WORD_WIDTH{grant[j]}});
            sel_last = sel_last | (input_last[j] & grant[j]);
        end
        cnt_hit   = (MAX_BEATS != 0) && (cnt == LIMIT_M1);
        beat_last = sel_last | cnt_hit;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= {{(N-1){1'b0}}, 1'b1};
            cnt   <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            ptr   <= ptr_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        ptr_next   = ptr;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (|input_valid) begin
                    state_next = BUSY;
                    grant_next = arb_gnt;
                    cnt_next   = '0;
                end
            end
            BUSY: begin
                if (accept) begin
                    if (cnt != CNT_MAX) begin
                        cnt_next = cnt + CW'(1);
                    end
                    if (beat_last) begin
                        state_next = IDLE;
                        grant_next = '0;
                        ptr_next   = {grant[N-2:0], grant[N-1]};
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        input_ready = (state == BUSY && buf_nf) ? grant : '0;
        accept      = |(input_valid & input_ready);
        pop         = output_valid & output_ready;
        occ_next    = 2'(output_valid) + 2'(skid_valid) + 2'(accept) - 2'(pop);
    end

    // Head register drives the outputs; the skid entry catches the beat that
    // was already accepted when the stall became visible.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            output_valid <= 1'b0;
            output_last  <= 1'b0;
            output_data  <= '0;
            skid_valid   <= 1'b0;
            skid_beat    <= '0;
            buf_nf       <= 1'b1;
        end else begin
            if (!output_valid || pop) begin
                if (skid_valid) begin
                    output_valid <= 1'b1;
                    {output_last, output_data} <= skid_beat;
                    skid_valid <= accept;
                    if (accept) begin
                        skid_beat <= {beat_last, sel_data};
                    end
                end else begin
                    output_valid <= accept;
                    if (accept) begin
                        {output_last, output_data} <= {beat_last, sel_data};
                    end
                end
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_beat  <= {beat_last, sel_data};
            end
            buf_nf <= (occ_next < 2'd2);
        end
    end

endmodule

// File: tb/tb_pipeline_merge_packet_scheduler.sv
// Bench for the packet merge scheduler: queued source traffic against a
// transaction-level round-robin model of the merged output stream.
module tb_pipeline_merge_packet_scheduler;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int MB = 16;

    logic            clock = 1'b0;
    logic            clear;
    logic [N-1:0]    input_valid, input_ready, input_last, grant;
    logic [W*N-1:0]  input_data;
    logic            output_valid, output_ready, output_last;
    logic [W-1:0]    output_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] src_q [N][$];
    logic [8:0] exp_q [$];
    int         out_cyc [$];
    int         ready_mode;
    bit         gap_en;

    always #5 clock = ~clock;

    pipeline_merge_packet_scheduler #(
        .WORD_WIDTH (W),
        .INPUT_COUNT(N),
        .MAX_BEATS  (MB)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .input_valid (input_valid),
        .input_ready (input_ready),
        .input_last  (input_last),
        .input_data  (input_data),
        .output_valid(output_valid),
        .output_ready(output_ready),
        .output_last (output_last),
        .output_data (output_data),
        .grant       (grant)
    );

    task automatic do_reset();
        clear        = 1'b1;
        input_valid  = '0;
        input_last   = '0;
        input_data   = '0;
        output_ready = 1'b0;
        for (int j = 0; j < N; j++) src_q[j].delete();
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1 clear = 1'b0;
    endtask

    // Round-robin over sources holding data, MAX_BEATS chunks with forced last.
    task automatic build_expected();
        logic [8:0] q [N][$];
        logic [8:0] b;
        int p, owner, chunk;
        for (int j = 0; j < N; j++) q[j] = src_q[j];
        exp_q.delete();
        p = 0;
        while (1) begin
            owner = -1;
            for (int i = 0; i < N; i++) begin
                if (owner < 0 && q[(p + i) % N].size() > 0) owner = (p + i) % N;
            end
            if (owner < 0) break;
            chunk = 0;
            while (1) begin
                b = q[owner].pop_front();
                chunk++;
                if (chunk == MB) b[8] = 1'b1;
                exp_q.push_back(b);
                if (b[8]) break;
            end
            p = (owner + 1) % N;
        end
    endtask

    task automatic drive_src(input int j);
        logic [8:0] f;
        if (src_q[j].size() > 0) begin
            f = src_q[j][0];
            input_valid[j]          = 1'b1;
            input_last[j]           = f[8];
            input_data[W*j +: W]    = f[7:0];
        end else begin
            input_valid[j] = 1'b0;
            input_last[j]  = 1'b0;
        end
    endtask

    task automatic set_ready(input int cyc);
        case (ready_mode)
            0: output_ready = 1'b1;
            1: output_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: output_ready = ($urandom_range(0, 2) != 0);
        endcase
    endtask

    task automatic run_traffic(input string name, input int max_cycles);
        int k [N];
        bit fire [N];
        int cyc, nbeat;
        bit done;
        logic [8:0] e, f;
        cyc = 0; nbeat = 0; done = 1'b0;
        out_cyc.delete();
        build_expected();
        for (int j = 0; j < N; j++) begin
            k[j] = 0;
            drive_src(j);
        end
        set_ready(0);
        while (!done && cyc < max_cycles) begin
            @(negedge clock);
            for (int j = 0; j < N; j++) fire[j] = input_valid[j] && input_ready[j];
            if (output_valid && output_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s extra_beat: got last=%b data=%h, required no beat", name, output_last, output_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({output_last, output_data} !== e) begin
                        n_err++;
                        $display("FAIL %s beat[%0d]: got last=%b data=%h, required last=%b data=%h",
                                 name, nbeat, output_last, output_data, e[8], e[7:0]);
                    end
                end
                out_cyc.push_back(cyc);
                nbeat++;
            end
            @(posedge clock);
            #1;
            cyc++;
            for (int j = 0; j < N; j++) begin
                if (fire[j]) begin
                    f = src_q[j].pop_front();
                    k[j] = f[8] ? 0 : k[j] + 1;
                    input_valid[j] = 1'b0;
                end
                if (!input_valid[j]) begin
                    if (src_q[j].size() > 0 && gap_en && (k[j] % MB) != 0 && $urandom_range(0, 2) == 0)
                        input_valid[j] = 1'b0;
                    else
                        drive_src(j);
                end
            end
            set_ready(cyc);
            if (exp_q.size() == 0) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s timeout: got %0d beats missing after %0d cycles, required 0", name, exp_q.size(), cyc);
        end
        output_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if (output_valid !== 1'b0 || grant !== '0) begin
            n_err++;
            $display("FAIL %s drain_idle: got valid=%b grant=%b, required valid=0 grant=0000", name, output_valid, grant);
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        for (int c = 0; c < 4; c++) begin
            input_valid  = 4'($urandom);
            input_last   = 4'($urandom);
            input_data   = 32'($urandom);
            output_ready = 1'($urandom);
            @(negedge clock);
            n_cmp++;
            if ({output_valid, output_last, output_data, grant, input_ready} !== '0) begin
                n_err++;
                $display("FAIL reset_held: got v=%b l=%b d=%h g=%b r=%b, required all 0",
                         output_valid, output_last, output_data, grant, input_ready);
            end
        end
        input_valid = '0;
        @(posedge clock);
        #1 clear = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({output_valid, output_last, output_data, grant, input_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_release: got v=%b l=%b d=%h g=%b r=%b, required all 0",
                     output_valid, output_last, output_data, grant, input_ready);
        end
        @(posedge clock);
        #1;
        input_valid = 4'b0001; input_last = 4'b0001; input_data = 32'h000000A5;
        output_ready = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (grant !== 4'b0000 || input_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL decision_cycle: got grant=%b ready=%b, required 0000/0000", grant, input_ready);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if (grant !== 4'b0001 || input_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL first_grant: got grant=%b ready=%b, required 0001/0001", grant, input_ready);
        end
        @(posedge clock);
        #1;
        input_valid = '0;
        n_cmp++;
        if (output_valid !== 1'b1 || output_data !== 8'hA5 || output_last !== 1'b1 || grant !== 4'b0000) begin
            n_err++;
            $display("FAIL first_beat: got v=%b d=%h l=%b g=%b, required v=1 d=a5 l=1 g=0000",
                     output_valid, output_data, output_last, grant);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if (output_valid !== 1'b0) begin
            n_err++;
            $display("FAIL first_pop: got v=%b, required 0", output_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] tags [N];
        tags[0] = 8'hA0; tags[1] = 8'hB0; tags[2] = 8'hC0; tags[3] = 8'hD0;
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < N; j++) src_q[j].push_back({1'b1, tags[j]});
        ready_mode = 0; gap_en = 1'b0;
        run_traffic("round_robin", 200);
        for (int i = 1; i < out_cyc.size(); i++) begin
            n_cmp++;
            if (out_cyc[i] - out_cyc[i-1] != 2) begin
                n_err++;
                $display("FAIL rr_bubble[%0d]: got spacing %0d cycles, required 2", i, out_cyc[i] - out_cyc[i-1]);
            end
        end
    endtask

    task automatic test_no_interleave();
        do_reset();
        for (int i = 1; i <= 5; i++) src_q[0].push_back({(i == 5), 8'(i)});
        for (int i = 0; i < 3; i++) src_q[1].push_back({(i == 2), 8'h11 + 8'(i)});
        ready_mode = 0; gap_en = 1'b0;
        run_traffic("no_interleave", 200);
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 8; i++) src_q[0].push_back({(i == 7), 8'($urandom)});
        ready_mode = 1; gap_en = 1'b0;
        run_traffic("backpressure", 300);
    endtask

    task automatic test_max_beats();
        do_reset();
        for (int i = 1; i <= 20; i++) src_q[2].push_back({(i == 20), 8'h20 + 8'(i)});
        src_q[3].push_back({1'b0, 8'h30});
        src_q[3].push_back({1'b1, 8'h31});
        ready_mode = 0; gap_en = 1'b0;
        run_traffic("max_beats", 300);
    endtask

    task automatic test_random();
        int len;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int j = 0; j < N; j++) begin
                for (int p = $urandom_range(0, 3); p > 0; p--) begin
                    len = $urandom_range(1, 24);
                    for (int i = 0; i < len; i++) src_q[j].push_back({(i == len - 1), 8'($urandom)});
                end
            end
            ready_mode = 2; gap_en = 1'b1;
            run_traffic("random", 6000);
        end
    endtask

    task automatic test_reset_mid();
        int idx;
        bit fire;
        do_reset();
        idx = 0;
        output_ready = 1'b1;
        input_valid = 4'b0001; input_last = 4'b0000; input_data[7:0] = 8'h61;
        for (int c = 0; c < 50 && idx < 3; c++) begin
            @(negedge clock);
            fire = input_valid[0] && input_ready[0];
            @(posedge clock);
            #1;
            if (fire) begin
                idx++;
                input_data[7:0] = 8'h61 + 8'(idx);
                input_last[0]   = (idx == 5);
            end
        end
        n_cmp++;
        if (idx != 3 || output_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_progress: got beats=%0d v=%b, required beats=3 v=1", idx, output_valid);
        end
        clear = 1'b1;
        #1;
        n_cmp++;
        if (output_valid !== 1'b0 || grant !== '0 || input_ready !== '0 || output_data !== '0) begin
            n_err++;
            $display("FAIL mid_clear_async: got v=%b g=%b r=%b d=%h, required all 0",
                     output_valid, grant, input_ready, output_data);
        end
        input_valid = '0;
        @(posedge clock);
        #1 clear = 1'b0;
        for (int i = 0; i < 3; i++) src_q[1].push_back({(i == 2), 8'h71 + 8'(i)});
        ready_mode = 0; gap_en = 1'b0;
        run_traffic("after_mid_reset", 200);
    endtask

    initial begin
        clear = 1'b1;
        input_valid = '0; input_last = '0; input_data = '0; output_ready = 1'b0;
        ready_mode = 0; gap_en = 1'b0;
        test_reset();
        test_round_robin();
        test_no_interleave();
        test_backpressure();
        test_max_beats();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
